pc_fetch_unit: RTL

//   Program-counter register and instruction-fetch sequencer; the stage directly upstream of the PC Incrementer.

---
 rtl/mips_fetch_pkg.sv | 11 +
 rtl/fetch_skid_buf.sv | 32 +++
 rtl/pc_fetch_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package mips_fetch_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register (valid + instruction + PC) used by the fetch stage.
module fetch_skid_buf
  import mips_fetch_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] din_instr,
  input  logic [AW-1:0]      din_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [AW-1:0]      pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= din_instr;
      pc    <= din_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and single-outstanding instruction-fetch sequencer.
// Define FETCH_SKID_EN to overlap the next fetch with a held instruction via a 1-entry skid.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned   AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [AW-1:0]      pc_q,
  input  logic [AW-1:0]      pc_plus1,
  input  logic               redirect_valid,
  input  logic [AW-1:0]      redirect_target,
  output logic               imem_req,
  output logic [AW-1:0]      imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [AW-1:0]      if_pc
);

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] addr_q;
  logic          addr_load;
  logic          kill_q, kill_d;
  logic          out_v_q, out_v_d;
  logic          out_load;
  logic          accept;

`ifdef FETCH_SKID_EN
  logic               skid_v;
  logic [INSTR_W-1:0] skid_instr;
  logic [AW-1:0]      skid_pc;
  logic               skid_load;
  logic               skid_pop;

  fetch_skid_buf #(.AW(AW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .clear     (redirect_valid | skid_pop),
    .din_instr (imem_rdata),
    .din_pc    (pc_q),
    .valid     (skid_v),
    .instr     (skid_instr),
    .pc        (skid_pc)
  );
`endif

  assign accept    = out_v_q & if_ready;
  assign imem_req  = (state_q == WAIT);
  assign imem_addr = addr_q;
  assign if_valid  = out_v_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    addr_load = 1'b0;
    out_load  = 1'b0;
    out_v_d   = out_v_q & ~accept;
`ifdef FETCH_SKID_EN
    skid_load = 1'b0;
    skid_pop  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        state_d   = WAIT;
        addr_load = 1'b1;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d    = 1'b0;
            addr_load = 1'b1;
          end else begin
            pc_d = pc_plus1;
`ifdef FETCH_SKID_EN
            // Skid is always empty while a request is outstanding.
            if (!out_v_q || accept) begin
              out_load  = 1'b1;
              addr_load = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = HOLD;
            end
`else
            out_load = 1'b1;
            state_d  = HOLD;
`endif
          end
        end
      end
      HOLD: begin
        if (accept) begin
          state_d   = WAIT;
          addr_load = 1'b1;
`ifdef FETCH_SKID_EN
          skid_pop  = skid_v;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (out_load) out_v_d = 1'b1;
`ifdef FETCH_SKID_EN
    if (skid_pop) out_v_d = 1'b1;
`endif

    // An unanswered request stays on the bus; its response is marked for dropping.
    if (redirect_valid) begin
      pc_d     = redirect_target;
      out_v_d  = 1'b0;
      out_load = 1'b0;
      state_d  = WAIT;
`ifdef FETCH_SKID_EN
      skid_load = 1'b0;
      skid_pop  = 1'b0;
`endif
      if (state_q == WAIT && !imem_rvalid) begin
        kill_d    = 1'b1;
        addr_load = 1'b0;
      end else begin
        kill_d    = 1'b0;
        addr_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      kill_q   <= 1'b0;
      addr_q   <= RESET_PC;
      out_v_q  <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      out_v_q <= out_v_d;
      if (addr_load) addr_q <= pc_d;
      if (out_load) begin
        if_instr <= imem_rdata;
        if_pc    <= pc_q;
      end
`ifdef FETCH_SKID_EN
      else if (skid_pop) begin
        if_instr <= skid_instr;
        if_pc    <= skid_pc;
      end
`endif
    end
  end

endmodule
